tri_mode_arbiter: RTL and testbench
===================================

# tri_mode_arbiter

Round-robin arbiter that shares one resource between three requesters, granting one at a time. It reuses the three-state mode encoding of the mode counter (00 → 10 → 01 → 00), so downstream mode-select logic can read the current owner directly from `mode`. It sits between the three requesting sub-blocks and the shared resource's mode select, and is fully synchronous to the system clock.

## Interface
Parameters:
- `HOLD_MAX`, default 8: maximum consecutive granted cycles per owner. Legal range 1..255; the hold counter is 8 bits. Used only when the timeout feature is compiled in.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  3  request lines; bit i belongs to requester i; level-sensitive.
- `gnt`  out  3  one-hot grant, registered; 000 when no owner.
- `mode`  out  2  code of the current or most recent owner: req0=00, req1=10, req2=01. Code 11 is illegal.
- `busy`  out  1  high while any `gnt` bit is high.
- `expire`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- States: IDLE (`gnt`=000) and GRANT (exactly one `gnt` bit high).
- Rotation order is req0 → req1 → req2 → req0. The search starts at the requester after the one `mode` names; the first requester found with `req` high wins.
- IDLE:
  - If `req` != 000, go to GRANT at the next edge, set `gnt` to the winner and `mode` to the winner's code, and clear the hold counter.
  - Otherwise remain in IDLE; `mode` keeps its value.
- GRANT:
  - While `req[owner]`=1, hold `gnt`.
  - When `req[owner]` is sampled 0, go to IDLE at the next edge with `gnt`=000.
  - Requests from non-owners are ignored until IDLE.
- Handshake:
  - A requester holds `req` until it sees `gnt`.
  - It releases the resource by dropping `req`.
  - Re-asserting `req` afterwards is a new request.
- Every release forces at least one IDLE cycle (`gnt`=000) between consecutive grants, including re-grant to the same requester.
- If `mode` is ever 11, treat it as 01 (search starts at req0) and load a legal code at the next grant.
- `busy` = OR of `gnt`, registered together with `gnt`.

## Timing
- Reset values: `gnt`=000, `mode`=01 (so req0 has first priority), `busy`=0, `expire`=0, hold counter=0, state IDLE.
- `rst` asserted mid-grant: the above values take effect at the next edge, regardless of `req`. Arbitration resumes on the first edge after `rst` deasserts.
- Latency from `req` to `gnt` is one edge: `req` high before edge N in IDLE gives `gnt` high after edge N.
- Latency from release to `gnt` low is one edge: `req[owner]` low before edge N gives `gnt`=000 after edge N.
- Owner drops `req` while others request: one IDLE cycle, then the next requester in rotation order is granted.
- A sole requester that releases and re-requests is re-granted after the one-cycle gap.

## Configuration
- Macro `TRI_ARB_TIMEOUT_EN`.
- Defined:
  - The hold counter increments every GRANT cycle.
  - At the edge that ends the `HOLD_MAX`-th granted cycle, if `req[owner]` is still 1: `gnt` goes to 000, the state goes to IDLE, and `expire`=1 for exactly that following cycle.
  - The revoked owner is lowest priority in the next search. If it is the only requester, it is re-granted after the gap.
  - A voluntary release on the same edge as the timeout counts as a release, with `expire`=0.
- Undefined:
  - No hold counter is built and `expire` is tied to 0.
  - A grant is held for as long as `req[owner]`=1.

## Test plan
- Reset: apply `rst` for 2 cycles with `req`=111 → `gnt`=000, `mode`=01, `busy`=0, `expire`=0 throughout reset.
- Single requester: `req`=001 → `gnt`=001 and `mode`=00 after 1 edge. Drop `req`[0] → `gnt`=000 after 1 edge and `mode` stays 00.
- Fairness: `req`=111, each owner drops its `req` after 2 granted cycles and re-raises it 1 cycle later → grant sequence 001, 010, 100, 001 with exactly one 000 cycle between grants; `mode` sequence 00, 10, 01, 00.
- Timeout (with `TRI_ARB_TIMEOUT_EN`, `HOLD_MAX`=4), `req`=011 held constantly → `gnt`=001 for 4 cycles, then `gnt`=000 with `expire`=1 for one cycle, then `gnt`=010 for 4 cycles; the pattern repeats alternating owners.
- No timeout (macro undefined), `req`=011 held for 300 cycles → `gnt`=001 for all 300 cycles; `expire` stays 0.
- Reset mid-operation: `rst` pulsed for 1 cycle while `gnt`=010 and `req`=111 → `gnt`=000 and `mode`=01 after that edge; the first grant after reset is 001.

Source files
------------

// File: rtl/tri_mode_arbiter.sv
// Round-robin 3-way arbiter; gnt rises 1 edge after req, drops 1 edge after release, with one forced IDLE gap.
// Requesters hold req until granted; define TRI_ARB_TIMEOUT_EN to revoke a grant after HOLD_MAX cycles.
module tri_mode_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] mode,
  output logic       busy,
  output logic       expire
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] last_idx;
  logic [1:0] nxt1;
  logic [1:0] nxt2;
  logic [1:0] win_idx;
  logic       own_req;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("tri_mode_arbiter: HOLD_MAX out of range 1..255");
  end

  function automatic logic [1:0] code_of(input logic [1:0] idx);
    case (idx)
      2'd0:    code_of = 2'b00;
      2'd1:    code_of = 2'b10;
      default: code_of = 2'b01;
    endcase
  endfunction

  // Illegal code 11 falls into the default and behaves like 01.
  always_comb begin
    case (mode)
      2'b00:   last_idx = 2'd0;
      2'b10:   last_idx = 2'd1;
      default: last_idx = 2'd2;
    endcase
  end

  always_comb begin
    nxt1    = (last_idx == 2'd2) ? 2'd0 : last_idx + 2'd1;
    nxt2    = (nxt1 == 2'd2) ? 2'd0 : nxt1 + 2'd1;
    win_idx = last_idx;
    if (req[nxt2]) win_idx = nxt2;
    if (req[nxt1]) win_idx = nxt1;
  end

  assign own_req = |(req & gnt);

`ifdef TRI_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 3'b000;
      mode     <= 2'b01;
      busy     <= 1'b0;
      expire   <= 1'b0;
      hold_cnt <= 8'd0;
    end else begin
      expire <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state    <= GRANT;
            gnt      <= 3'b001 << win_idx;
            mode     <= code_of(win_idx);
            busy     <= 1'b1;
            hold_cnt <= 8'd0;
          end
        end
        default: begin
          // A release on the timeout edge wins over the revoke.
          if (!own_req) begin
            state <= IDLE;
            gnt   <= 3'b000;
            busy  <= 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            state  <= IDLE;
            gnt    <= 3'b000;
            busy   <= 1'b0;
            expire <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
      endcase
    end
  end
`else
  assign expire = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 3'b000;
      mode  <= 2'b01;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state <= GRANT;
            gnt   <= 3'b001 << win_idx;
            mode  <= code_of(win_idx);
            busy  <= 1'b1;
          end
        end
        default: begin
          if (!own_req) begin
            state <= IDLE;
            gnt   <= 3'b000;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_tri_mode_arbiter.sv
// Directed bench for tri_mode_arbiter: reset, single requester, fairness, timeout or hold, mid-grant reset.
module tb_tri_mode_arbiter;

`ifdef TRI_ARB_TIMEOUT_EN
  localparam int HM = 4;
`else
  localparam int HM = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] mode;
  logic       busy;
  logic       expire;

  int n_checks = 0;
  int n_errors = 0;

  tri_mode_arbiter #(.HOLD_MAX(HM)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .mode   (mode),
    .busy   (busy),
    .expire (expire)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] eg, input logic [1:0] em,
                         input logic eb, input logic ee);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".mode"}, 32'(mode), 32'(em));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".expire"}, 32'(expire), 32'(ee));
  endtask

  logic [1:0] codes [3] = '{2'b00, 2'b10, 2'b01};
  int         order [4] = '{0, 1, 2, 0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req = 3'b111;
    step(); chk_out("reset1", 3'b000, 2'b01, 1'b0, 1'b0);
    step(); chk_out("reset2", 3'b000, 2'b01, 1'b0, 1'b0);

    rst = 1'b0;
    req = 3'b000;
    step(); chk_out("idle", 3'b000, 2'b01, 1'b0, 1'b0);

    // Single requester: grant, then release.
    req = 3'b001;
    step(); chk_out("single_gnt", 3'b001, 2'b00, 1'b1, 1'b0);
    req = 3'b000;
    step(); chk_out("single_rel", 3'b000, 2'b00, 1'b0, 1'b0);

    // Re-grant of a sole requester after one gap cycle.
    req = 3'b001;
    step(); chk_out("regrant", 3'b001, 2'b00, 1'b1, 1'b0);
    req = 3'b000;
    step(); chk_out("regrant_rel", 3'b000, 2'b00, 1'b0, 1'b0);

    // Fairness from reset priority.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 3'b111;
    foreach (order[i]) begin
      step(); chk_out($sformatf("fair%0d_a", i), 3'(1 << order[i]), codes[order[i]], 1'b1, 1'b0);
      step(); chk_out($sformatf("fair%0d_b", i), 3'(1 << order[i]), codes[order[i]], 1'b1, 1'b0);
      req[order[i]] = 1'b0;
      step(); chk_out($sformatf("fair%0d_gap", i), 3'b000, codes[order[i]], 1'b0, 1'b0);
      req[order[i]] = 1'b1;
    end

    // Next in rotation after req0 is req1; reset mid-grant.
    step(); chk_out("pre_rst", 3'b010, 2'b10, 1'b1, 1'b0);
    rst = 1'b1;
    step(); chk_out("mid_rst", 3'b000, 2'b01, 1'b0, 1'b0);
    rst = 1'b0;
    step(); chk_out("post_rst", 3'b001, 2'b00, 1'b1, 1'b0);

    rst = 1'b1;
    req = 3'b011;
    step();
    rst = 1'b0;
`ifdef TRI_ARB_TIMEOUT_EN
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < HM; c++) begin
        step(); chk_out($sformatf("to%0d_c%0d", r, c), 3'(1 << (r % 2)), codes[r % 2], 1'b1, 1'b0);
      end
      step(); chk_out($sformatf("to%0d_exp", r), 3'b000, codes[r % 2], 1'b0, 1'b1);
    end
    // Voluntary release exactly on the timeout edge is not an expiry.
    for (int c = 0; c < HM; c++) begin
      step(); chk_out($sformatf("vrel_c%0d", c), 3'b001, 2'b00, 1'b1, 1'b0);
    end
    req = 3'b000;
    step(); chk_out("vrel_end", 3'b000, 2'b00, 1'b0, 1'b0);
    req[0] = 1'b0;
    step(); chk_out("vrel_gap", 3'b000, 2'b00, 1'b0, 1'b0);
`else
    for (int c = 0; c < 300; c++) begin
      step();
      chk($sformatf("hold%0d.gnt", c), 32'(gnt), 32'h1);
      chk($sformatf("hold%0d.expire", c), 32'(expire), 32'h0);
    end
    req = 3'b010;
    step(); chk_out("hold_rel", 3'b000, 2'b00, 1'b0, 1'b0);
    step(); chk_out("hold_next", 3'b010, 2'b10, 1'b1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
